// File: rtl/ctrl_data_split_if.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_data_split_if
//  Description : Bundle of the input stream and the two split output
//                channels (data / ctrl) of ctrl_data_split, with
//                master (producer/consumer side) and slave (block side)
//                modports.
//  Revision    : 1.0  initial release
// ============================================================================
interface ctrl_data_split_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 32,
    parameter int DEPTH      = 16
);
    localparam int c_LVL_W = $clog2(DEPTH) + 1;

    logic [CTRL_WIDTH+DATA_WIDTH-1:0] din;
    logic                             din_valid;
    logic                             din_ready;
    logic [DATA_WIDTH-1:0]            data_out;
    logic                             data_valid;
    logic                             data_ready;
    logic [CTRL_WIDTH-1:0]            ctrl_out;
    logic                             ctrl_valid;
    logic                             ctrl_ready;
    logic                             empty;
    logic [c_LVL_W-1:0]               data_level;
    logic [c_LVL_W-1:0]               ctrl_level;

    modport master (
        output din, din_valid, data_ready, ctrl_ready,
        input  din_ready, data_out, data_valid, ctrl_out, ctrl_valid,
               empty, data_level, ctrl_level
    );

    modport slave (
        input  din, din_valid, data_ready, ctrl_ready,
        output din_ready, data_out, data_valid, ctrl_out, ctrl_valid,
               empty, data_level, ctrl_level
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_data_split.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_data_split
//  Description : Splits each packed {ctrl, data} input word into two
//                independent first-word-fall-through buffers. A word is
//                only accepted when both buffers have room, so entry k of
//                each channel always comes from the same input word.
//                Optional macro CTRL_DATA_SPLIT_STATS_EN adds a saturating
//                16-bit stall_count output (cycles with din_valid=1 and
//                din_ready=0).
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_data_split #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    ctrl_data_split_if.slave        bus
`ifdef CTRL_DATA_SPLIT_STATS_EN
    ,
    output logic [15:0]             stall_count
`endif
);
    localparam int               c_AW        = $clog2(DEPTH);
    localparam int               c_LVL_W     = c_AW + 1;
    localparam logic [c_LVL_W-1:0] c_DEPTH_LVL = c_LVL_W'(DEPTH);

    // Storage: contents are never reset; levels alone define validity.
    logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
    logic [CTRL_WIDTH-1:0] r_ctrl_mem [DEPTH];

    logic [c_AW-1:0]    r_data_wr, r_data_rd;
    logic [c_AW-1:0]    r_ctrl_wr, r_ctrl_rd;
    logic [c_LVL_W-1:0] r_data_level, r_ctrl_level;

    logic w_din_ready;
    logic w_push;
    logic w_data_valid, w_ctrl_valid;
    logic w_data_pop, w_ctrl_pop;

    // Accept only when neither buffer is full; a same-cycle pop does not
    // free a slot for a push (no pass-through path).
    assign w_din_ready  = (r_data_level != c_DEPTH_LVL) && (r_ctrl_level != c_DEPTH_LVL);
    assign w_push       = bus.din_valid && w_din_ready;
    assign w_data_valid = (r_data_level != '0);
    assign w_ctrl_valid = (r_ctrl_level != '0);
    assign w_data_pop   = w_data_valid && bus.data_ready;
    assign w_ctrl_pop   = w_ctrl_valid && bus.ctrl_ready;

    assign bus.din_ready  = w_din_ready;
    assign bus.data_valid = w_data_valid;
    assign bus.ctrl_valid = w_ctrl_valid;
    assign bus.data_out   = w_data_valid ? r_data_mem[r_data_rd] : '0;
    assign bus.ctrl_out   = w_ctrl_valid ? r_ctrl_mem[r_ctrl_rd] : '0;
    assign bus.empty      = !w_data_valid && !w_ctrl_valid;
    assign bus.data_level = r_data_level;
    assign bus.ctrl_level = r_ctrl_level;

    // Write both halves of an accepted word into their buffers together.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_data_mem[r_data_wr] <= bus.din[DATA_WIDTH-1:0];
            r_ctrl_mem[r_ctrl_wr] <= bus.din[CTRL_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
        end
    end

    // Data channel pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_wr    <= '0;
            r_data_rd    <= '0;
            r_data_level <= '0;
        end else begin
            if (w_push)     r_data_wr <= r_data_wr + c_AW'(1);
            if (w_data_pop) r_data_rd <= r_data_rd + c_AW'(1);
            case ({w_push, w_data_pop})
                2'b10:   r_data_level <= r_data_level + c_LVL_W'(1);
                2'b01:   r_data_level <= r_data_level - c_LVL_W'(1);
                default: r_data_level <= r_data_level;
            endcase
        end
    end

    // Ctrl channel pointers and occupancy, popped independently of data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl_wr    <= '0;
            r_ctrl_rd    <= '0;
            r_ctrl_level <= '0;
        end else begin
            if (w_push)     r_ctrl_wr <= r_ctrl_wr + c_AW'(1);
            if (w_ctrl_pop) r_ctrl_rd <= r_ctrl_rd + c_AW'(1);
            case ({w_push, w_ctrl_pop})
                2'b10:   r_ctrl_level <= r_ctrl_level + c_LVL_W'(1);
                2'b01:   r_ctrl_level <= r_ctrl_level - c_LVL_W'(1);
                default: r_ctrl_level <= r_ctrl_level;
            endcase
        end
    end

`ifdef CTRL_DATA_SPLIT_STATS_EN
    logic [15:0] r_stall_count;

    // Count back-pressured cycles, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (bus.din_valid && !w_din_ready && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_data_split.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_data_split
//  Description : Directed self-checking bench for ctrl_data_split
//                (DEPTH=16, 32-bit fields). Word k carries
//                data=32'h1000+k and ctrl=32'hC000+k.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ctrl_data_split;
    localparam int DW = 32;
    localparam int CW = 32;
    localparam int DP = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    ctrl_data_split_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEPTH(DP)) bus ();

`ifdef CTRL_DATA_SPLIT_STATS_EN
    logic [15:0] stall_count;
`endif

    ctrl_data_split #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEPTH(DP)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus)
`ifdef CTRL_DATA_SPLIT_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] word(input int k);
        logic [31:0] c;
        logic [31:0] d;
        c = 32'hC000 + k;
        d = 32'h1000 + k;
        return {c, d};
    endfunction

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.data_ready = 1'b0;
        bus.ctrl_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_din_ready"}, 64'(bus.din_ready), 64'd1);
        check({tag, "_dvalid"},    64'(bus.data_valid), 64'd0);
        check({tag, "_cvalid"},    64'(bus.ctrl_valid), 64'd0);
        check({tag, "_dout"},      64'(bus.data_out), 64'd0);
        check({tag, "_cout"},      64'(bus.ctrl_out), 64'd0);
        check({tag, "_empty"},     64'(bus.empty), 64'd1);
        check({tag, "_dlevel"},    64'(bus.data_level), 64'd0);
        check({tag, "_clevel"},    64'(bus.ctrl_level), 64'd0);
    endtask

    initial begin
        int sent;
        int rcv_d;
        int rcv_c;
        int cyc;
        logic pushed;

        n_checks = 0;
        n_errors = 0;

        // Reset state
        do_reset();
        check_idle("reset");
`ifdef CTRL_DATA_SPLIT_STATS_EN
        check("reset_stall", 64'(stall_count), 64'd0);
`endif

        // Single word, latency 1
        bus.din       = 64'h0000_00A5_0000_0011;
        bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        check("one_dvalid", 64'(bus.data_valid), 64'd1);
        check("one_cvalid", 64'(bus.ctrl_valid), 64'd1);
        check("one_dout",   64'(bus.data_out), 64'h11);
        check("one_cout",   64'(bus.ctrl_out), 64'hA5);
        check("one_empty",  64'(bus.empty), 64'd0);
        check("one_dlevel", 64'(bus.data_level), 64'd1);
        check("one_clevel", 64'(bus.ctrl_level), 64'd1);

        // Fill to 16 with both readies low
        do_reset();
        for (int k = 0; k < DP; k++) begin
            bus.din       = word(k);
            bus.din_valid = 1'b1;
            step();
        end
        check("full_din_ready", 64'(bus.din_ready), 64'd0);
        check("full_dlevel",    64'(bus.data_level), 64'd16);
        check("full_clevel",    64'(bus.ctrl_level), 64'd16);
        // 17th word held for 10 cycles must not be accepted
        bus.din = word(99);
        for (int k = 0; k < 10; k++) step();
        check("hold_dlevel", 64'(bus.data_level), 64'd16);
        check("hold_clevel", 64'(bus.ctrl_level), 64'd16);
        check("hold_dout",   64'(bus.data_out), 64'h1000);
        check("hold_cout",   64'(bus.ctrl_out), 64'hC000);
`ifdef CTRL_DATA_SPLIT_STATS_EN
        check("stall_count", 64'(stall_count), 64'd10);
`endif

        // Drain data only; din_valid stays high, no push may slip in
        bus.data_ready = 1'b1;
        for (int k = 0; k < DP; k++) begin
            check("drain_dout", 64'(bus.data_out), 64'(32'h1000 + k));
            step();
            check("drain_din_ready", 64'(bus.din_ready), 64'd0);
            check("drain_clevel",    64'(bus.ctrl_level), 64'd16);
        end
        bus.din_valid  = 1'b0;
        bus.data_ready = 1'b0;
        check("drained_dlevel", 64'(bus.data_level), 64'd0);
        check("drained_dvalid", 64'(bus.data_valid), 64'd0);
        check("drained_dout",   64'(bus.data_out), 64'd0);
        check("drained_cout",   64'(bus.ctrl_out), 64'hC000);
        // One ctrl pop reopens the input
        bus.ctrl_ready = 1'b1;
        step();
        bus.ctrl_ready = 1'b0;
        check("cpop_clevel",    64'(bus.ctrl_level), 64'd15);
        check("cpop_din_ready", 64'(bus.din_ready), 64'd1);
        check("cpop_cout",      64'(bus.ctrl_out), 64'hC001);

        // Mid-stream reset with 5 words buffered; handshake at reset edge ignored
        do_reset();
        for (int k = 0; k < 5; k++) begin
            bus.din       = word(k);
            bus.din_valid = 1'b1;
            step();
        end
        check("pre_rst_dlevel", 64'(bus.data_level), 64'd5);
        bus.din        = word(7);
        bus.data_ready = 1'b1;
        bus.ctrl_ready = 1'b1;
        rst_n          = 1'b0;
        step();
        rst_n          = 1'b1;
        bus.din_valid  = 1'b0;
        bus.data_ready = 1'b0;
        bus.ctrl_ready = 1'b0;
        check_idle("midrst");

        // Stream 40 words with random independent readies
        do_reset();
        sent  = 0;
        rcv_d = 0;
        rcv_c = 0;
        cyc   = 0;
        bus.din        = word(0);
        bus.din_valid  = 1'b1;
        bus.data_ready = 1'($urandom_range(0, 1));
        bus.ctrl_ready = 1'($urandom_range(0, 1));
        while ((rcv_d < 40 || rcv_c < 40) && cyc < 2000) begin
            pushed = bus.din_valid && bus.din_ready;
            if (bus.data_valid && bus.data_ready) begin
                check("stream_dout", 64'(bus.data_out), 64'(32'h1000 + rcv_d));
                rcv_d++;
            end
            if (bus.ctrl_valid && bus.ctrl_ready) begin
                check("stream_cout", 64'(bus.ctrl_out), 64'(32'hC000 + rcv_c));
                rcv_c++;
            end
            step();
            cyc++;
            if (pushed) sent++;
            check("stream_dlevel", 64'(bus.data_level), 64'(sent - rcv_d));
            check("stream_clevel", 64'(bus.ctrl_level), 64'(sent - rcv_c));
            bus.din        = word(sent);
            bus.din_valid  = (sent < 40);
            bus.data_ready = 1'($urandom_range(0, 1));
            bus.ctrl_ready = 1'($urandom_range(0, 1));
        end
        check("stream_done", 64'(cyc < 2000), 64'd1);
        check("stream_sent", 64'(sent), 64'd40);
        check("stream_empty", 64'(bus.empty), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ctrl_data_split.md
CTRL_DATA_SPLIT -- requirements
Module: ctrl_data_split

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the data field and data output channel.
REQ-002 Parameter CTRL_WIDTH, default 32: width of the ctrl field and ctrl output channel.
REQ-003 Parameter DEPTH, default 16: entries per output buffer; power of two, at least 2.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 din  in  CTRL_WIDTH+DATA_WIDTH  packed input word {ctrl, data}; ctrl in the MSBs.
REQ-007 din_valid  in  1  input word present.
REQ-008 din_ready  out  1  block can accept the input word this cycle.
REQ-009 data_out  out  DATA_WIDTH  head of the data buffer.
REQ-010 data_valid  out  1  data_out holds a valid entry.
REQ-011 data_ready  in  1  downstream pops the data head.
REQ-012 ctrl_out  out  CTRL_WIDTH  head of the ctrl buffer.
REQ-013 ctrl_valid  out  1  ctrl_out holds a valid entry.
REQ-014 ctrl_ready  in  1  downstream pops the ctrl head.
REQ-015 empty  out  1  both buffers hold zero entries.
REQ-016 data_level, ctrl_level  out  $clog2(DEPTH)+1 each  current occupancy of each buffer.

Function
REQ-017 An input word is accepted on a rising edge when din_valid=1 and din_ready=1.
REQ-018 din_ready SHALL be 1 only when neither buffer is full: data_level<DEPTH and ctrl_level<DEPTH.
REQ-019 An accepted word writes din[DATA_WIDTH-1:0] into the data buffer and din[CTRL_WIDTH+DATA_WIDTH-1:DATA_WIDTH] into the ctrl buffer on the same edge.
REQ-020 Both buffers are first-word-fall-through: a word accepted at edge N into an empty buffer is visible with valid=1 in the cycle after edge N (latency 1).
REQ-021 Each channel pops independently: a pop occurs on an edge when <ch>_valid=1 and <ch>_ready=1.
REQ-022 A pop SHALL never disturb the other channel's contents or level.
REQ-023 <ch>_valid=1 iff <ch>_level>0; <ch>_out SHALL read 0 when <ch>_valid=0.
REQ-024 On a simultaneous push and pop on one channel, that channel's level is unchanged and the head advances.
REQ-025 A full buffer SHALL NOT accept a push, even when the same cycle pops it; no pass-through path exists.
REQ-026 Read and write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-027 Output order per channel SHALL equal input order; entry k on data_out and entry k on ctrl_out originate from the same input word.
REQ-028 A pop while empty or a push while full is impossible by construction; ready and valid gating make these cases no-ops.

Reset
REQ-029 While rst_n=0 at a rising edge, pointers and levels clear to 0 and buffer contents are discarded.
REQ-030 After reset: din_ready=1, data_valid=0, ctrl_valid=0, data_out=0, ctrl_out=0, empty=1, both levels 0.
REQ-031 A reset asserted mid-stream discards all buffered words; a handshake coinciding with the reset edge is ignored.

Configuration
REQ-032 Macro CTRL_DATA_SPLIT_STATS_EN, when defined, adds output stall_count (16 bits): a saturating count of cycles with din_valid=1 and din_ready=0.
REQ-033 With the macro defined, stall_count resets to 0 and holds at 16'hFFFF once reached.
REQ-034 Without the macro, the port and its counter are absent and all other behaviour is identical.

Verification
REQ-035 Reset, then push {ctrl=32'hA5, data=32'h11} -> next cycle: data_valid=1, ctrl_valid=1, data_out=32'h11, ctrl_out=32'hA5, empty=0, both levels 1.
REQ-036 Push 16 words with both readies at 0 -> din_ready=0 after the 16th push; a 17th word held valid is not accepted; both levels 16.
REQ-037 Fill with 16 words, then drain data only -> data_level falls to 0; ctrl_level stays 16; din_ready stays 0 until one ctrl pop.
REQ-038 Stream 40 words with continuous push and random independent readies -> both channels output words 0..39 in order with matching pairs; pointers wrap without loss.
REQ-039 Assert rst_n=0 for 1 cycle with 5 words buffered -> next cycle: empty=1, valids=0, outputs 0, levels 0.
REQ-040 With CTRL_DATA_SPLIT_STATS_EN defined, hold din_valid=1 on a full block for 10 cycles -> stall_count=10.
